// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, next-PC select, IRQ pending latch, IF/ID register.
// Optional IF_IRQ_SYNC_EN puts a two-flop synchronizer on irq.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
  parameter logic [31:0] EXP_VEC   = 32'h8000_0008,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump_i,
  input  logic [31:0] jt,
  input  logic        jump_r,
  input  logic [31:0] jr_target,
  input  logic        id_irq,
  input  logic        id_exp,
  input  logic        irq,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        ifid_irq
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic        redirect;
  logic        irq_pending;
  logic        irq_in;
  logic        pend_set;
  logic        pend_clr;

  assign imem_addr = pc;
  assign pc_plus4  = {pc[31], pc[30:0] + 31'd4};
  assign redirect  = br_taken | id_exp | id_irq | jump_r | jump_i;

`ifdef IF_IRQ_SYNC_EN
  logic irq_s1;
  logic irq_s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_s1 <= 1'b0;
      irq_s2 <= 1'b0;
    end else begin
      irq_s1 <= irq;
      irq_s2 <= irq_s1;
    end
  end

  assign irq_in = irq_s2;
`else
  assign irq_in = irq;
`endif

  // A branch squashes the ID instruction, so its id_irq must not consume the IRQ.
  assign pend_set = irq_in & ~pc[31];
  assign pend_clr = id_irq & ~br_taken;

  always_comb begin
    pc_next = pc_plus4;
    if (br_taken)    pc_next = br_target;
    else if (id_exp) pc_next = EXP_VEC;
    else if (id_irq) pc_next = IRQ_VEC;
    else if (jump_r) pc_next = jr_target;
    else if (jump_i) pc_next = jt;
    else if (stall)  pc_next = pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_pending <= 1'b0;
    end else if (pend_clr) begin
      irq_pending <= 1'b0;
    end else if (pend_set) begin
      irq_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc            <= RESET_PC;
      ifid_instr    <= NOP_INSTR;
      ifid_pc       <= 32'h0;
      ifid_pc_plus4 <= 32'h0;
      ifid_valid    <= 1'b0;
      ifid_irq      <= 1'b0;
    end else begin
      pc <= pc_next;
      if (redirect) begin
        ifid_instr    <= NOP_INSTR;
        ifid_pc       <= 32'h0;
        ifid_pc_plus4 <= 32'h0;
        ifid_valid    <= 1'b0;
        ifid_irq      <= 1'b0;
      end else if (!stall) begin
        ifid_instr    <= imem_rdata;
        ifid_pc       <= pc;
        ifid_pc_plus4 <= pc_plus4;
        ifid_valid    <= 1'b1;
        ifid_irq      <= irq_pending & ~pc[31];
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed fetch/redirect/IRQ cases
// followed by randomized control traffic against a behavioural model.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC  = 32'h8000_0004;
  localparam logic [31:0] EXP_VEC  = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall, br_taken, jump_i, jump_r, id_irq, id_exp, irq;
  logic [31:0] br_target, jt, jr_target;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc_plus4;
  logic        ifid_valid, ifid_irq;

  int n_pass = 0;
  int n_total = 0;

  if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .jump_i        (jump_i),
    .jt            (jt),
    .jump_r        (jump_r),
    .jr_target     (jr_target),
    .id_irq        (id_irq),
    .id_exp        (id_exp),
    .irq           (irq),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid),
    .ifid_irq      (ifid_irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h2008_0001;
    return (a * 32'd2654435761) ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem(imem_addr);

  // Reference state
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;
  logic        m_valid, m_irq, m_pend;
  logic [1:0]  m_sync;

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = 0; m_ipc = 0; m_ipc4 = 0;
    m_valid = 0; m_irq = 0; m_pend = 0; m_sync = 0;
  endtask

  task automatic model_update();
    logic [31:0] p4;
    logic        redir, irq_eff, new_pend;
    p4 = m_pc + 32'd4;
    p4[31] = m_pc[31];
    redir = br_taken || id_exp || id_irq || jump_r || jump_i;
`ifdef IF_IRQ_SYNC_EN
    irq_eff = m_sync[1];
`else
    irq_eff = irq;
`endif
    new_pend = m_pend;
    if (id_irq && !br_taken) new_pend = 0;
    else if (irq_eff && !m_pc[31]) new_pend = 1;
    if (redir) begin
      m_instr = 0; m_ipc = 0; m_ipc4 = 0; m_valid = 0; m_irq = 0;
    end else if (!stall) begin
      m_instr = mem(m_pc); m_ipc = m_pc; m_ipc4 = p4;
      m_valid = 1; m_irq = m_pend && !m_pc[31];
    end
    if (br_taken) m_pc = br_target;
    else if (id_exp) m_pc = EXP_VEC;
    else if (id_irq) m_pc = IRQ_VEC;
    else if (jump_r) m_pc = jr_target;
    else if (jump_i) m_pc = jt;
    else if (!stall) m_pc = p4;
    m_pend = new_pend;
    m_sync = {m_sync[0], irq};
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
  endtask

  task automatic compare_all();
    check("imem_addr", imem_addr, m_pc);
    check("ifid_instr", ifid_instr, m_instr);
    check("ifid_pc", ifid_pc, m_ipc);
    check("ifid_pc_plus4", ifid_pc_plus4, m_ipc4);
    check("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
    check("ifid_irq", {31'b0, ifid_irq}, {31'b0, m_irq});
    check("irq_pending", {31'b0, dut.irq_pending}, {31'b0, m_pend});
  endtask

  task automatic clr();
    stall = 0; br_taken = 0; jump_i = 0; jump_r = 0;
    id_irq = 0; id_exp = 0; irq = 0;
    br_target = 0; jt = 0; jr_target = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom;
    t[1:0] = 2'b00;
    case ($urandom_range(0, 3))
      0: t[31] = 1'b1;
      1: t = 32'h7FFF_FFF8;
      default: t[31] = 1'b0;
    endcase
    return t;
  endfunction

  initial begin
    clr();
    reset = 0;
    model_reset();
    #12;
    compare_all();
    check("rst_addr", imem_addr, RESET_PC);
    reset = 1;

    step();
    check("tp_first_instr", ifid_instr, 32'h2008_0001);
    check("tp_first_pc", ifid_pc, 32'h8000_0000);
    check("tp_first_pc4", ifid_pc_plus4, 32'h8000_0004);
    check("tp_next_addr", imem_addr, 32'h8000_0004);

    jump_i = 1; jt = 32'h0040_0010; step(); clr();
    stall = 1; step();
    check("tp_stall1", imem_addr, 32'h0040_0010);
    step();
    check("tp_stall2", imem_addr, 32'h0040_0010);
    stall = 0; step();
    check("tp_resume", imem_addr, 32'h0040_0014);
    check("tp_resume_pc", ifid_pc, 32'h0040_0010);

    jump_i = 1; jt = 32'h0040_0008; step(); clr();
    jump_i = 1; jt = 32'h0040_0100; step(); clr();
    check("tp_jump_addr", imem_addr, 32'h0040_0100);
    check("tp_jump_bubble", {31'b0, ifid_valid}, 32'h0);

    br_taken = 1; br_target = 32'h0040_0200;
    stall = 1; jump_i = 1; jt = 32'h0040_0100;
    step(); clr();
    check("tp_br_addr", imem_addr, 32'h0040_0200);
    check("tp_br_bubble", {31'b0, ifid_valid}, 32'h0);

    jump_i = 1; jt = 32'h0040_0020; step(); clr();
    irq = 1; step(); irq = 0;
    for (int i = 0; i < 4; i++) step();
    id_irq = 1; step(); clr();
    check("tp_irq_vec", imem_addr, IRQ_VEC);
    step();
    jump_i = 1; jt = 32'h8000_0010; step(); clr();
    irq = 1;
    for (int i = 0; i < 4; i++) step();
    irq = 0;
    check("tp_sup_no_pend", {31'b0, dut.irq_pending}, 32'h0);

    jump_r = 1; jr_target = 32'h0040_0300; step(); clr();
    irq = 1; step(); step(); irq = 0;
    #2 reset = 0;
    model_reset();
    #1;
    check("tp_async_pc", imem_addr, RESET_PC);
    check("tp_async_valid", {31'b0, ifid_valid}, 32'h0);
    check("tp_async_pend", {31'b0, dut.irq_pending}, 32'h0);
    #3 reset = 1;

    for (int i = 0; i < 600; i++) begin
      stall     = ($urandom_range(0, 99) < 25);
      br_taken  = ($urandom_range(0, 99) < 7);
      id_exp    = ($urandom_range(0, 99) < 4);
      id_irq    = ($urandom_range(0, 99) < 8);
      jump_r    = ($urandom_range(0, 99) < 6);
      jump_i    = ($urandom_range(0, 99) < 6);
      irq       = ($urandom_range(0, 99) < 25);
      br_target = rand_target();
      jt        = rand_target();
      jr_target = rand_target();
      step();
    end
    clr();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
